// File: rtl/decode_exec_buffer_way0_if.sv
// rtl/decode_exec_buffer_way0_if.sv - decoder-to-execute handshake and payload bundle
interface decode_exec_buffer_way0_if #(
  parameter int XLEN = 32
);
  // decoder side
  logic            valid_i;
  logic            ready_o;
  logic [4:0]      rdAddr_i;
  logic            rdWriteEnable_i;
  logic [XLEN-1:0] rs1ReadData_i;
  logic [XLEN-1:0] rs2ReadData_i;
  logic [XLEN-1:0] imm_i;
  logic [6:0]      opCode_i;
  logic [2:0]      funct3_i;
  logic [6:0]      funct7_i;
  logic [4:0]      shamt_i;
  logic [1:0]      pID_i;
  // execute side
  logic            valid_o;
  logic            ready_i;
  logic [4:0]      rdAddr_o;
  logic            rdWriteEnable_o;
  logic [XLEN-1:0] rs1ReadData_o;
  logic [XLEN-1:0] rs2ReadData_o;
  logic [XLEN-1:0] imm_o;
  logic [6:0]      opCode_o;
  logic [2:0]      funct3_o;
  logic [6:0]      funct7_o;
  logic [4:0]      shamt_o;
  logic [1:0]      pID_o;
  logic [1:0]      count_o;

  // the buffer itself
  modport slave (
    input  valid_i, rdAddr_i, rdWriteEnable_i, rs1ReadData_i, rs2ReadData_i,
           imm_i, opCode_i, funct3_i, funct7_i, shamt_i, pID_i, ready_i,
    output ready_o, valid_o, rdAddr_o, rdWriteEnable_o, rs1ReadData_o,
           rs2ReadData_o, imm_o, opCode_o, funct3_o, funct7_o, shamt_o,
           pID_o, count_o
  );

  // whoever drives decode and consumes execute
  modport master (
    output valid_i, rdAddr_i, rdWriteEnable_i, rs1ReadData_i, rs2ReadData_i,
           imm_i, opCode_i, funct3_i, funct7_i, shamt_i, pID_i, ready_i,
    input  ready_o, valid_o, rdAddr_o, rdWriteEnable_o, rs1ReadData_o,
           rs2ReadData_o, imm_o, opCode_o, funct3_o, funct7_o, shamt_o,
           pID_o, count_o
  );
endinterface

// File: rtl/decode_exec_buffer_way0.sv
// rtl/decode_exec_buffer_way0.sv - two-entry in-order decode/execute skid buffer
module decode_exec_buffer_way0 #(
  parameter int XLEN = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush_i,
  decode_exec_buffer_way0_if.slave  bus
);

  typedef struct packed {
    logic [4:0]      rd_addr;
    logic            rd_we;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic [XLEN-1:0] imm;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [4:0]      shamt;
    logic [1:0]      pid;
  } entry_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t state_q;
  entry_t head_q;
  entry_t tail_q;
  entry_t in_entry;
  logic   push;
  logic   pop;

  assign in_entry = {bus.rdAddr_i, bus.rdWriteEnable_i, bus.rs1ReadData_i,
                     bus.rs2ReadData_i, bus.imm_i, bus.opCode_i, bus.funct3_i,
                     bus.funct7_i, bus.shamt_i, bus.pID_i};

  // ready depends only on state (and reset) so execute back-pressure never
  // forms a combinational path back to the decoder
  assign bus.ready_o = !reset && (state_q != FULL);
  assign bus.valid_o = (state_q != EMPTY);

  assign push = bus.valid_i && bus.ready_o;
  assign pop  = bus.valid_o && bus.ready_i;

  // head slot always feeds execute directly
  assign bus.rdAddr_o        = head_q.rd_addr;
  assign bus.rdWriteEnable_o = head_q.rd_we;
  assign bus.rs1ReadData_o   = head_q.rs1;
  assign bus.rs2ReadData_o   = head_q.rs2;
  assign bus.imm_o           = head_q.imm;
  assign bus.opCode_o        = head_q.opcode;
  assign bus.funct3_o        = head_q.funct3;
  assign bus.funct7_o        = head_q.funct7;
  assign bus.shamt_o         = head_q.shamt;
  assign bus.pID_o           = head_q.pid;

  // occupancy is a direct decode of the state register
  always_comb begin
    bus.count_o = 2'd0;
    case (state_q)
      ONE:     bus.count_o = 2'd1;
      FULL:    bus.count_o = 2'd2;
      default: bus.count_o = 2'd0;
    endcase
  end

  // buffer FSM with slot updates; flush only drops validity, slots keep data
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
    end else if (flush_i) begin
      state_q <= EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (push) begin
            head_q  <= in_entry;
            state_q <= ONE;
          end
        end
        ONE: begin
          if (push && pop) begin
            head_q  <= in_entry;
          end else if (push) begin
            tail_q  <= in_entry;
            state_q <= FULL;
          end else if (pop) begin
            state_q <= EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            head_q  <= tail_q;
            state_q <= ONE;
          end
        end
        default: state_q <= EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_decode_exec_buffer_way0.sv
// tb/tb_decode_exec_buffer_way0.sv - randomized self-checking bench against a queue model
module tb_decode_exec_buffer_way0;

  localparam int XLEN = 32;
  localparam int PW   = 5 + 1 + 3 * XLEN + 7 + 3 + 7 + 5 + 2;

  logic clk;
  logic reset;
  logic flush_i;

  decode_exec_buffer_way0_if #(.XLEN(XLEN)) bus ();

  decode_exec_buffer_way0 #(.XLEN(XLEN)) dut (
    .clk     (clk),
    .reset   (reset),
    .flush_i (flush_i),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fails  = 0;

  logic [PW-1:0] model_q[$];
  logic          after_reset = 1'b0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [PW-1:0] mk(input logic [4:0] rd, input logic [XLEN-1:0] imm, input logic [1:0] pid);
    return {rd, 1'b1, 32'h1111_0000, 32'h2222_0000, imm, 7'h13, 3'h0, 7'h0, 5'h0, pid};
  endfunction

  function automatic logic [PW-1:0] rand_payload();
    logic [127:0] t;
    t = {$urandom, $urandom, $urandom, $urandom};
    return t[PW-1:0];
  endfunction

  function automatic logic [PW-1:0] head_out();
    return {bus.rdAddr_o, bus.rdWriteEnable_o, bus.rs1ReadData_o, bus.rs2ReadData_o,
            bus.imm_o, bus.opCode_o, bus.funct3_o, bus.funct7_o, bus.shamt_o, bus.pID_o};
  endfunction

  // one clock: drive at negedge, model advances at posedge, outputs checked at next negedge
  task automatic cycle(input logic rst, input logic fl, input logic v, input logic r, input logic [PW-1:0] p);
    logic do_push;
    logic do_pop;
    reset       = rst;
    flush_i     = fl;
    bus.valid_i = v;
    bus.ready_i = r;
    {bus.rdAddr_i, bus.rdWriteEnable_i, bus.rs1ReadData_i, bus.rs2ReadData_i, bus.imm_i,
     bus.opCode_i, bus.funct3_i, bus.funct7_i, bus.shamt_i, bus.pID_i} = p;
    #1;
    check("ready_o", {127'd0, bus.ready_o}, {127'd0, (!rst && model_q.size() < 2)});
    @(posedge clk);
    if (rst) begin
      model_q.delete();
      after_reset = 1'b1;
    end else begin
      after_reset = 1'b0;
      do_push = v && (model_q.size() < 2);
      do_pop  = r && (model_q.size() > 0);
      if (fl) begin
        model_q.delete();
      end else begin
        if (do_pop) void'(model_q.pop_front());
        if (do_push) model_q.push_back(p);
      end
    end
    @(negedge clk);
    check("valid_o", {127'd0, bus.valid_o}, {127'd0, model_q.size() > 0});
    check("count_o", {126'd0, bus.count_o}, 128'(model_q.size()));
    if (model_q.size() > 0) check("payload", {2'b00, head_out()}, {2'b00, model_q[0]});
    if (after_reset) check("payload_reset", {2'b00, head_out()}, 128'd0);
  endtask

  logic [PW-1:0] pa, pb, pc;

  initial begin
    reset = 1'b1;
    flush_i = 1'b0;
    bus.valid_i = 1'b0;
    bus.ready_i = 1'b0;
    {bus.rdAddr_i, bus.rdWriteEnable_i, bus.rs1ReadData_i, bus.rs2ReadData_i, bus.imm_i,
     bus.opCode_i, bus.funct3_i, bus.funct7_i, bus.shamt_i, bus.pID_i} = '0;
    @(negedge clk);

    // reset, overriding offered traffic
    cycle(1, 1, 1, 1, rand_payload());
    cycle(1, 0, 0, 0, '0);

    // single push into empty shows up next cycle
    cycle(0, 0, 1, 0, mk(5'd3, 32'h10, 2'd0));
    check("rdAddr_o_single", 128'(bus.rdAddr_o), 128'd3);
    check("imm_o_single", 128'(bus.imm_o), 128'h10);
    cycle(0, 0, 0, 1, '0);

    // fill with A,B under back-pressure, then drain
    pa = mk(5'd1, 32'hA, 2'd1);
    pb = mk(5'd2, 32'hB, 2'd2);
    cycle(0, 0, 1, 0, pa);
    cycle(0, 0, 1, 0, pb);
    cycle(0, 0, 1, 0, rand_payload());
    check("imm_o_holdA", 128'(bus.imm_o), 128'hA);
    cycle(0, 0, 0, 1, '0);
    check("imm_o_thenB", 128'(bus.imm_o), 128'hB);
    cycle(0, 0, 0, 1, '0);
    cycle(0, 0, 0, 1, '0);

    // streaming with ready held high
    for (int i = 0; i < 8; i++) begin
      cycle(0, 0, 1, 1, mk(5'(i), 32'(i), 2'(i % 4)));
      check("stream_valid", {127'd0, bus.valid_o}, 128'd1);
      check("stream_pid", 128'(bus.pID_o), 128'(i % 4));
      check("stream_count_le1", {127'd0, bus.count_o > 2'd1}, 128'd0);
    end
    cycle(0, 0, 0, 1, '0);

    // flush while full drops everything including the offered entry
    cycle(0, 0, 1, 0, rand_payload());
    cycle(0, 0, 1, 0, rand_payload());
    cycle(0, 1, 1, 0, rand_payload());
    cycle(0, 0, 0, 0, '0);

    // simultaneous push and pop while holding one entry
    pc = mk(5'd7, 32'hC, 2'd3);
    cycle(0, 0, 1, 0, pa);
    cycle(0, 0, 1, 1, pc);
    check("imm_o_C", 128'(bus.imm_o), 128'hC);
    cycle(0, 0, 0, 1, '0);

    // reset asserted while full
    cycle(0, 0, 1, 0, rand_payload());
    cycle(0, 0, 1, 0, rand_payload());
    cycle(1, 0, 0, 1, '0);
    cycle(1, 0, 1, 1, rand_payload());
    cycle(0, 0, 0, 0, '0);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      cycle(($urandom_range(0, 63) == 0), ($urandom_range(0, 15) == 0),
            ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0), rand_payload());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/decode_exec_buffer_way0.md
DECODE_EXEC_BUFFER_WAY0 -- requirements
Module: decode_exec_buffer_way0

Interface
REQ-001 SHALL have parameter XLEN, default 32, the operand/immediate data width.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port flush_i  input  1  jump flush: discards all buffered entries.
REQ-005 SHALL have port valid_i  input  1  decoder entry valid.
REQ-006 SHALL have port ready_o  output  1  buffer can accept an entry this cycle.
REQ-007 SHALL have input ports rdAddr_i[5], rdWriteEnable_i[1], rs1ReadData_i[XLEN], rs2ReadData_i[XLEN], imm_i[XLEN], opCode_i[7], funct3_i[3], funct7_i[7], shamt_i[5], pID_i[2]: the decoded instruction payload.
REQ-008 SHALL have port valid_o  output  1  head entry valid toward execute.
REQ-009 SHALL have port ready_i  input  1  execute accepts the head entry.
REQ-010 SHALL have output ports rdAddr_o, rdWriteEnable_o, rs1ReadData_o, rs2ReadData_o, imm_o, opCode_o, funct3_o, funct7_o, shamt_o, pID_o: same widths as the matching inputs, head-entry payload.
REQ-011 SHALL have port count_o  output  2  current occupancy (0..2).

Function
REQ-012 SHALL be a 2-entry in-order FIFO (head slot, tail slot) with states EMPTY, ONE, FULL; count_o = 0/1/2 respectively.
REQ-013 SHALL define push = valid_i && ready_o and pop = valid_o && ready_i.
REQ-014 SHALL drive ready_o = !reset && (state != FULL), combinationally from state only (no dependence on ready_i).
REQ-015 SHALL drive valid_o = (state != EMPTY); payload outputs SHALL come directly from the head slot registers.
REQ-016 SHALL keep the payload outputs stable while valid_o && !ready_i (no change without a pop or flush).
REQ-017 Transitions: EMPTY+push -> ONE (input written to head).
REQ-018 ONE+push, no pop -> FULL (input written to tail); ONE+pop, no push -> EMPTY; ONE+push+pop -> ONE (input written to head, same cycle).
REQ-019 FULL+pop -> ONE (tail moved to head); push impossible in FULL because ready_o=0.
REQ-020 Latency: an entry pushed into EMPTY SHALL appear on valid_o/payload the next cycle; no combinational valid_i->valid_o or payload path.
REQ-021 Throughput: with ready_i held high, the buffer SHALL sustain one entry per cycle with no bubbles.
REQ-022 flush_i SHALL force next state EMPTY, overriding any push or pop that cycle; the entry offered that cycle is dropped; valid_o=0 the following cycle.
REQ-023 A pop occurring in the same cycle as flush_i SHALL still count as accepted by execute (handshake completes); the buffer only discards remaining entries.
REQ-024 Slot registers of a discarded or popped entry need not be cleared; only state/count define validity.
REQ-025 No entry SHALL be duplicated, dropped (except by flush), or reordered.

Reset
REQ-026 While reset is high at a clock edge: state EMPTY, count_o=0, valid_o=0, all payload registers 0; reset SHALL override flush_i, valid_i and ready_i.
REQ-027 ready_o SHALL be 0 while reset is high and 1 in the first cycle after reset deasserts.
REQ-028 Reset asserted mid-operation (ONE or FULL) SHALL discard all entries at that edge.

Verification
REQ-029 Reset then single push rdAddr_i=5'd3, imm_i=32'h10 with ready_i=0 -> next cycle valid_o=1, rdAddr_o=3, imm_o=32'h10, count_o=1, ready_o=1.
REQ-030 Push A then B with ready_i=0 -> count_o=2, ready_o=0, output stays A; raise ready_i -> A popped, then B next cycle, then valid_o=0.
REQ-031 Stream 8 entries pID 0,1,2,3,0,1,2,3 with ready_i=1 every cycle -> 8 consecutive valid_o cycles, order preserved, count_o never exceeds 1.
REQ-032 FULL, assert flush_i with valid_i=1 and ready_i=0 -> next cycle count_o=0, valid_o=0, offered entry absent from output.
REQ-033 ONE, simultaneous push C and pop -> count_o stays 1, next output is C.
REQ-034 FULL, assert reset with ready_i=1 -> next cycle valid_o=0, all payload outputs 0, ready_o=0 until reset deasserts.
